fsm_cnt_dispatcher: RTL and testbench
=====================================

FSM_CNT_DISPATCHER -- requirements
Module: fsm_cnt_dispatcher

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning job FIFO entries (power of two, >= 2).
REQ-002 The block SHALL have parameter CNT_W, default 7, meaning job count width, matching the counter's i_num_cnt.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 Port reset_n, input, 1 bit: synchronous active-low reset.
REQ-006 Port i_valid, input, 1 bit: job push request.
REQ-007 Port i_num, input, CNT_W bits: job count to enqueue.
REQ-008 Port o_ready, output, 1 bit: FIFO can accept a push this cycle.
REQ-009 Port i_idle, input, 1 bit: the downstream counter is in its idle state.
REQ-010 Port i_done, input, 1 bit: the downstream counter is in its done state.
REQ-011 Port o_run, output, 1 bit: one-cycle start pulse to the counter.
REQ-012 Port o_num_cnt, output, CNT_W bits: count for the active job, registered.
REQ-013 Port o_busy, output, 1 bit: a job has been issued and is not yet done.
REQ-014 Port o_level, output, log2(DEPTH)+1 bits: current FIFO occupancy.
REQ-015 Port o_err, output, 1 bit: one-cycle pulse on a rejected push.

Function
REQ-016 A push SHALL occur on a cycle with i_valid=1 and o_ready=1; i_num is written at the tail.
REQ-017 o_ready SHALL equal (o_level != DEPTH); it is combinational from state only, not from i_valid.
REQ-018 i_valid=1 while o_ready=0 SHALL be a rejected push: no write; o_err=1 on the next cycle.
REQ-019 The FSM SHALL have states S_IDLE=2'b00, S_ISSUE=2'b01 and S_WAIT=2'b10; the unused encoding SHALL go to S_IDLE.
REQ-020 From S_IDLE, the FSM SHALL go to S_ISSUE when o_level!=0 and i_idle=1; otherwise it stays in S_IDLE.
REQ-021 On the S_IDLE->S_ISSUE edge, the head entry SHALL be popped into o_num_cnt.
REQ-022 In S_ISSUE, o_run SHALL be 1 for exactly one cycle; the FSM SHALL then go unconditionally to S_WAIT.
REQ-023 In S_WAIT, the FSM SHALL return to S_IDLE on the cycle after i_done=1 is sampled.
REQ-024 o_busy SHALL be 1 in S_ISSUE and S_WAIT.
REQ-025 o_num_cnt SHALL stay stable from the pop until the next pop.
REQ-026 Minimum job-to-job gap: after i_done, the next o_run SHALL come no earlier than 2 cycles later (S_IDLE, then S_ISSUE).
REQ-027 A push and a pop in the same cycle SHALL leave o_level unchanged; the pushed data is preserved.
REQ-028 A push into an empty FIFO SHALL NOT be issued in the same cycle; the earliest o_run is 2 cycles after the push.
REQ-029 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-030 o_level SHALL change by at most 1 per cycle.
REQ-031 i_done outside S_WAIT SHALL be ignored.
REQ-032 o_run, o_busy and o_err SHALL be registered outputs with no glitches.

Reset
REQ-033 With reset_n=0 at a rising edge, the block SHALL clear the FSM to S_IDLE, both pointers and o_level to 0, and o_num_cnt, o_run, o_busy and o_err to 0.
REQ-034 Reset mid-job (S_ISSUE or S_WAIT) SHALL discard the active job and all queued jobs.
REQ-035 o_ready SHALL be 1 on the first cycle after reset is released.

Configuration
REQ-036 With DISPATCH_ZERO_DROP_EN defined, a push with i_num==0 SHALL be rejected (no write, o_err pulse), so the counter never receives a zero count.
REQ-037 Without DISPATCH_ZERO_DROP_EN, i_num==0 SHALL be enqueued and issued like any other value.

Verification
REQ-038 Reset, then push i_num=5 with i_idle=1 -> o_run pulses 2 cycles later with o_num_cnt=5, o_busy=1; i_done pulse -> o_busy=0 one cycle later.
REQ-039 Push 4 jobs (3, 7, 1, 9) with i_idle=0 -> o_level=4, o_ready=0; a fifth push -> o_err pulse and o_level stays 4.
REQ-040 Drain the queue from REQ-039 with a counter model -> issue order is 3, 7, 1, 9; the gap between i_done and the next o_run is at least 2 cycles.
REQ-041 Push and pop in the same cycle at o_level=2 -> o_level stays 2; push 6 more jobs over time to wrap the pointers -> FIFO order is preserved.
REQ-042 Assert reset_n=0 during S_WAIT with o_level=3 -> next cycle o_level=0, o_busy=0, o_run=0, o_num_cnt=0.
REQ-043 Push i_num=0 -> with DISPATCH_ZERO_DROP_EN: o_err=1 and o_level=0; without it: o_level=1 and the job is issued with o_num_cnt=0.

Source files
------------

// File: rtl/fsm_cnt_dispatcher.sv
// Job FIFO feeding a counter: pops one job at a time, pulses o_run, waits for i_done.
// Optional DISPATCH_ZERO_DROP_EN rejects zero-count pushes.
module fsm_cnt_dispatcher #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 7,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    input  logic [CNT_W-1:0] i_num,
    output logic             o_ready,
    input  logic             i_idle,
    input  logic             i_done,
    output logic             o_run,
    output logic [CNT_W-1:0] o_num_cnt,
    output logic             o_busy,
    output logic [AW:0]      o_level,
    output logic             o_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10
    } state_t;

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic [CNT_W-1:0] r_num_cnt;
    logic             r_run;
    logic             r_busy;
    logic             r_err;
    logic             w_pop;
    logic             w_push;

    assign o_ready   = (r_level != LVL_FULL);
    assign o_level   = r_level;
    assign o_num_cnt = r_num_cnt;
    assign o_run     = r_run;
    assign o_busy    = r_busy;
    assign o_err     = r_err;

`ifdef DISPATCH_ZERO_DROP_EN
    assign w_push = i_valid & o_ready & (|i_num);
`else
    assign w_push = i_valid & o_ready;
`endif

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if ((r_level != '0) && i_idle) begin
                    w_next = S_ISSUE;
                    w_pop  = 1'b1;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (i_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_num_cnt <= '0;
            r_run     <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= (w_next == S_ISSUE);
            r_busy  <= (w_next != S_IDLE);
            r_err   <= i_valid & ~w_push;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr    <= r_rptr + 1'b1;
                r_num_cnt <= r_mem[r_rptr];
            end
            // Simultaneous push and pop leaves occupancy unchanged
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_num;
    end

endmodule

// File: tb/tb_fsm_cnt_dispatcher.sv
// Bench for fsm_cnt_dispatcher: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_fsm_cnt_dispatcher;

    localparam int DEPTH = 4;
    localparam int CNT_W = 7;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             i_valid = 1'b0;
    logic [CNT_W-1:0] i_num = '0;
    logic             i_idle = 1'b0;
    logic             i_done = 1'b0;
    logic             o_ready;
    logic             o_run;
    logic [CNT_W-1:0] o_num_cnt;
    logic             o_busy;
    logic [AW:0]      o_level;
    logic             o_err;

    fsm_cnt_dispatcher #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_valid   (i_valid),
        .i_num     (i_num),
        .o_ready   (o_ready),
        .i_idle    (i_idle),
        .i_done    (i_done),
        .o_run     (o_run),
        .o_num_cnt (o_num_cnt),
        .o_busy    (o_busy),
        .o_level   (o_level),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference model: a job queue plus "job active" and "start pulse" flags
    int               q[$];
    bit               m_busy = 0;
    bit               m_run  = 0;
    bit               m_err  = 0;
    int               m_num  = 0;
    int               cyc    = 0;
    int               done_cyc = 0;
    bit               done_ok  = 0;
    logic [CNT_W-1:0] issued[$];

    always @(posedge clk) begin
        bit pop;
        bit acc;
        if (!reset_n) begin
            q.delete();
            m_busy  = 0;
            m_run   = 0;
            m_err   = 0;
            m_num   = 0;
            done_ok = 0;
        end else begin
            pop = !m_busy && (q.size() != 0) && i_idle;
            acc = i_valid && (q.size() != DEPTH);
`ifdef DISPATCH_ZERO_DROP_EN
            acc = acc && (i_num != 0);
`endif
            m_err = i_valid && !acc;
            if (pop) begin
                m_num  = q.pop_front();
                m_run  = 1;
                m_busy = 1;
            end else if (m_run) begin
                m_run = 0;
            end else if (m_busy && i_done) begin
                m_busy   = 0;
                done_cyc = cyc;
                done_ok  = 1;
            end
            if (acc) q.push_back(int'(i_num));
        end
        cyc++;
    end

    always @(posedge clk) begin
        #1;
        chk("level", int'(o_level), q.size());
        chk("ready", int'(o_ready), int'(q.size() != DEPTH));
        chk("run",   int'(o_run),   int'(m_run));
        chk("busy",  int'(o_busy),  int'(m_busy));
        chk("err",   int'(o_err),   int'(m_err));
        chk("num",   int'(o_num_cnt), m_num);
        if (o_run) begin
            issued.push_back(o_num_cnt);
            if (done_ok) chk("gap", int'((cyc - done_cyc) >= 2), 1);
        end
    end

    task automatic step(input logic v, input logic [CNT_W-1:0] n,
                        input logic idl, input logic dn);
        @(negedge clk);
        i_valid = v;
        i_num   = n;
        i_idle  = idl;
        i_done  = dn;
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, '0, 1'b1, 1'($urandom_range(0, 2) == 0));
        repeat (16) step(1'b0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        int e1[4];
        int nxt;
        logic v;
        e1 = '{3, 7, 1, 9};

        repeat (2) step(1'b0, '0, 1'b0, 1'b0);
        chk("rst_level", int'(o_level), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_run", int'(o_run), 0);
        chk("rst_num", int'(o_num_cnt), 0);
        reset_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        chk("rel_ready", int'(o_ready), 1);

        step(1'b1, 7'd5, 1'b1, 1'b0);
        chk("p5_level", int'(o_level), 1);
        chk("p5_norun", int'(o_run), 0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("p5_run", int'(o_run), 1);
        chk("p5_num", int'(o_num_cnt), 5);
        chk("p5_busy", int'(o_busy), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("p5_wait_busy", int'(o_busy), 1);
        step(1'b0, '0, 1'b1, 1'b1);
        chk("p5_done_busy", int'(o_busy), 0);

        step(1'b1, 7'd3, 1'b0, 1'b0);
        step(1'b1, 7'd7, 1'b0, 1'b0);
        step(1'b1, 7'd1, 1'b0, 1'b0);
        step(1'b1, 7'd9, 1'b0, 1'b0);
        chk("full_level", int'(o_level), 4);
        chk("full_ready", int'(o_ready), 0);
        step(1'b1, 7'd11, 1'b0, 1'b0);
        chk("ovf_err", int'(o_err), 1);
        chk("ovf_level", int'(o_level), 4);
        issued.delete();
        drain(40);
        chk("order_n", issued.size(), 4);
        for (int i = 0; i < 4 && i < issued.size(); i++)
            chk("order", int'(issued[i]), e1[i]);

        issued.delete();
        step(1'b1, 7'd20, 1'b0, 1'b0);
        step(1'b1, 7'd21, 1'b0, 1'b0);
        chk("pp_pre", int'(o_level), 2);
        step(1'b1, 7'd22, 1'b1, 1'b0);
        chk("pp_level", int'(o_level), 2);
        nxt = 23;
        for (int k = 0; k < 200 && nxt <= 27; k++) begin
            v = o_ready & 1'($urandom_range(0, 1));
            step(v, 7'(nxt), 1'b1, 1'($urandom_range(0, 2) == 0));
            if (v) nxt++;
        end
        chk("wrap_pushed", nxt, 28);
        drain(8);
        chk("wrap_n", issued.size(), 8);
        for (int i = 0; i < 8 && i < issued.size(); i++)
            chk("wrap_order", int'(issued[i]), 20 + i);

        step(1'b1, 7'd30, 1'b1, 1'b0);
        step(1'b1, 7'd31, 1'b1, 1'b0);
        step(1'b1, 7'd32, 1'b0, 1'b0);
        step(1'b1, 7'd33, 1'b0, 1'b0);
        chk("mid_level", int'(o_level), 3);
        chk("mid_busy", int'(o_busy), 1);
        reset_n = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0);
        chk("mid_rst_level", int'(o_level), 0);
        chk("mid_rst_busy", int'(o_busy), 0);
        chk("mid_rst_run", int'(o_run), 0);
        chk("mid_rst_num", int'(o_num_cnt), 0);
        reset_n = 1'b1;
        step(1'b0, '0, 1'b0, 1'b0);
        chk("mid_rel_ready", int'(o_ready), 1);

        step(1'b1, 7'd0, 1'b0, 1'b0);
`ifdef DISPATCH_ZERO_DROP_EN
        chk("zero_err", int'(o_err), 1);
        chk("zero_level", int'(o_level), 0);
`else
        chk("zero_err", int'(o_err), 0);
        chk("zero_level", int'(o_level), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("zero_run", int'(o_run), 1);
        chk("zero_num", int'(o_num_cnt), 0);
`endif
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);

        repeat (3000) begin
            reset_n = ($urandom_range(0, 199) != 0);
            step(1'($urandom_range(0, 2) != 0),
                 CNT_W'($urandom_range(0, (1 << CNT_W) - 1)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
